// File: rtl/lm32_trace_ctrl.sv
// Retired-instruction trace capture for the LM32 W stage: circular {pc, insn} buffer
// with arm/trigger/post-trigger sequencing and in-order readout. Optional macro: LM32_TRACE_PC_FILTER_EN.
module lm32_trace_ctrl #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_w,
    input  logic                  kill_w,
    input  logic [29:0]           pc_w,
    input  logic [31:0]           instruction_w,
    input  logic                  arm_i,
    input  logic                  trig_en_i,
    input  logic [29:0]           trig_pc_i,
    input  logic                  trig_ext_i,
    input  logic [DEPTH_LOG2-1:0] post_cnt_i,
    input  logic [29:0]           filt_lo_i,
    input  logic [29:0]           filt_hi_i,
    input  logic                  rd_req_i,
    output logic                  rd_ack_o,
    output logic [29:0]           rd_pc_o,
    output logic [31:0]           rd_insn_o,
    output logic                  rd_last_o,
    output logic [1:0]            state_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, post_q;
    logic [CW-1:0]   count_q, rd_cnt_q;
    logic            rd_ack_q, rd_last_q;
    logic [29:0]     rd_pc_q;
    logic [31:0]     rd_insn_q;
    logic [61:0]     mem [DEPTH];

    logic            win_hit, commit, capture, trig, rd_last_d;
    logic [AW-1:0]   wr_ptr_d, oldest_d;
    logic [CW-1:0]   count_d;

`ifdef LM32_TRACE_PC_FILTER_EN
    assign win_hit = (pc_w >= filt_lo_i) && (pc_w <= filt_hi_i);
`else
    logic unused_filt;
    assign unused_filt = ^{filt_lo_i, filt_hi_i};
    assign win_hit     = 1'b1;
`endif

    always_comb begin
        commit    = valid_w & ~kill_w & win_hit;
        capture   = commit & ~arm_i & ((state_q == S_ARMED) || (state_q == S_POST));
        // The PC trigger is qualified by commit, so a filtered-out PC never fires it
        trig      = (commit & trig_en_i & (pc_w == trig_pc_i)) | trig_ext_i;
        wr_ptr_d  = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d   = (capture && (count_q != FULL)) ? count_q + 1'b1 : count_q;
        // Once the buffer has wrapped, the oldest entry sits at the write pointer
        oldest_d  = (count_d == FULL) ? wr_ptr_d : '0;
        rd_last_d = ((rd_cnt_q + 1'b1) == count_q);
    end

    always_ff @(posedge clk_i) begin
        if (capture)
            mem[wr_ptr_q] <= {pc_w, instruction_w};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            post_q    <= '0;
            count_q   <= '0;
            rd_cnt_q  <= '0;
            rd_ack_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_pc_q   <= '0;
            rd_insn_q <= '0;
        end else begin
            rd_ack_q  <= 1'b0;
            rd_last_q <= 1'b0;
            if (arm_i) begin
                state_q  <= S_ARMED;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                post_q   <= '0;
                count_q  <= '0;
                rd_cnt_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
                case (state_q)
                    S_ARMED: begin
                        if (trig) begin
                            post_q <= post_cnt_i;
                            if (post_cnt_i == '0) begin
                                state_q  <= S_DONE;
                                rd_ptr_q <= oldest_d;
                            end else begin
                                state_q  <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (capture) begin
                            post_q <= post_q - 1'b1;
                            if (post_q == AW'(1)) begin
                                state_q  <= S_DONE;
                                rd_ptr_q <= oldest_d;
                            end
                        end
                    end
                    S_DONE: begin
                        if (count_q == '0) begin
                            state_q <= S_IDLE;
                        end else if (rd_req_i) begin
                            rd_ack_q  <= 1'b1;
                            rd_pc_q   <= mem[rd_ptr_q][61:32];
                            rd_insn_q <= mem[rd_ptr_q][31:0];
                            rd_last_q <= rd_last_d;
                            rd_ptr_q  <= rd_ptr_q + 1'b1;
                            rd_cnt_q  <= rd_cnt_q + 1'b1;
                            if (rd_last_d)
                                state_q <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_ack_o  = rd_ack_q;
    assign rd_pc_o   = rd_pc_q;
    assign rd_insn_o = rd_insn_q;
    assign rd_last_o = rd_last_q;
    assign state_o   = state_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_lm32_trace_ctrl.sv
// Directed + randomized bench for lm32_trace_ctrl against a queue-based trace model.
module tb_lm32_trace_ctrl;

    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid = 1'b0, kill = 1'b0, arm = 1'b0, trig_en = 1'b0, ext = 1'b0, rd_req = 1'b0;
    logic [29:0]   pc = '0, trig_pc = '0, flo = '0, fhi = '1;
    logic [31:0]   insn = '0;
    logic [DL-1:0] post_cnt = '0;
    logic          rd_ack, rd_last;
    logic [29:0]   rd_pc;
    logic [31:0]   rd_insn;
    logic [1:0]    state;
    logic [DL:0]   count;

    int n_vec = 0, n_err = 0;

    // model: the trace is simply the list of captured {pc,insn}, capped at DEPTH
    int          mst, rem, ridx;
    logic [61:0] mq[$];
    bit          e_ack, e_last;
    logic [61:0] e_dat;

    lm32_trace_ctrl #(.DEPTH_LOG2(DL)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_w(valid), .kill_w(kill), .pc_w(pc),
        .instruction_w(insn), .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .trig_ext_i(ext), .post_cnt_i(post_cnt), .filt_lo_i(flo), .filt_hi_i(fhi),
        .rd_req_i(rd_req), .rd_ack_o(rd_ack), .rd_pc_o(rd_pc), .rd_insn_o(rd_insn),
        .rd_last_o(rd_last), .state_o(state), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [29:0] p);
`ifdef LM32_TRACE_PC_FILTER_EN
        return (p >= flo) && (p <= fhi);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        mst = 0; rem = 0; ridx = 0; mq.delete();
        e_ack = 0; e_last = 0; e_dat = '0;
    endtask

    task automatic push();
        mq.push_back({pc, insn});
        if (mq.size() > DEPTH) void'(mq.pop_front());
    endtask

    task automatic model_clk();
        bit c;
        c = valid && !kill && in_win(pc);
        e_ack = 0; e_last = 0;
        if (arm) begin
            mst = 1; mq.delete(); ridx = 0;
        end else begin
            case (mst)
                1: begin
                    if (c) push();
                    if ((c && trig_en && pc == trig_pc) || ext) begin
                        rem = int'(post_cnt);
                        mst = (rem == 0) ? 3 : 2;
                    end
                end
                2: if (c) begin
                    push();
                    rem--;
                    if (rem == 0) mst = 3;
                end
                3: if (mq.size() == 0) mst = 0;
                   else if (rd_req) begin
                       e_ack  = 1;
                       e_dat  = mq[ridx];
                       e_last = (ridx == mq.size() - 1);
                       ridx++;
                       if (e_last) mst = 0;
                   end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("state", 64'(state), 64'(mst));
        chk("count", 64'(count), 64'(mq.size()));
        chk("rd_ack", 64'(rd_ack), 64'(e_ack));
        chk("rd_last", 64'(rd_last), 64'(e_last));
        if (e_ack) begin
            chk("rd_pc", 64'(rd_pc), 64'(e_dat[61:32]));
            chk("rd_insn", 64'(rd_insn), 64'(e_dat[31:0]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        #1;
        check_outputs();
    endtask

    task automatic clear_in();
        valid = 0; kill = 0; arm = 0; ext = 0; rd_req = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_rd_pc", 64'(rd_pc), 64'd0);
        chk("rst_rd_insn", 64'(rd_insn), 64'd0);
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic commit(input logic [29:0] p);
        valid = 1; pc = p; insn = $urandom;
        step();
        valid = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        step();
        arm = 0;
    endtask

    initial begin
        #2;
        // 1: reset, idle commits ignored, arm
        do_reset();
        commit(30'h10); commit(30'h11);
        chk("idle_count", 64'(count), 64'd0);
        do_arm();
        chk("armed_state", 64'(state), 64'd1);

        // 2: PC trigger with post count 3
        trig_en = 1; trig_pc = 30'h100; post_cnt = 3;
        for (int p = 'hFC; p <= 'h104; p++) commit(30'(p));
        chk("t2_state", 64'(state), 64'd3);
        chk("t2_count", 64'(count), 64'd8);
        rd_req = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_pc_order", 64'(rd_pc), 64'('hFC + i));
        end
        rd_req = 0;
        step();
        chk("t2_idle", 64'(state), 64'd0);
        trig_en = 0;

        // 3: wrap then external trigger, post 0
        do_arm();
        for (int p = 0; p < 100; p++) commit(30'(p));
        ext = 1; post_cnt = 0;
        step();
        ext = 0;
        chk("t3_state", 64'(state), 64'd3);
        chk("t3_count", 64'(count), 64'd64);
        rd_req = 1;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("t3_pc_order", 64'(rd_pc), 64'(36 + i));
        end
        chk("t3_last", 64'(rd_last), 64'd1);
        rd_req = 0;
        step();

        // 4: races
        do_arm();
        commit(30'h1);
        arm = 1; valid = 1; pc = 30'h2;
        step();
        clear_in();
        chk("t4_arm_drop", 64'(count), 64'd0);
        kill = 1;
        for (int i = 0; i < 4; i++) commit(30'($urandom_range(0, 255)));
        kill = 0;
        chk("t4_kill", 64'(count), 64'd0);
        rd_req = 1;
        step();
        rd_req = 0;
        chk("t4_armed_noack", 64'(rd_ack), 64'd0);

        // 5: back-to-back read of 5 entries
        trig_en = 1; trig_pc = 30'h304; post_cnt = 0;
        for (int p = 'h300; p < 'h305; p++) commit(30'(p));
        trig_en = 0;
        chk("t5_count", 64'(count), 64'd5);
        rd_req = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_ack", 64'(rd_ack), 64'd1);
        end
        rd_req = 0;
        step();
        chk("t5_idle", 64'(state), 64'd0);

`ifdef LM32_TRACE_PC_FILTER_EN
        // 6: capture window
        do_arm();
        flo = 30'h200; fhi = 30'h20F; trig_en = 1; trig_pc = 30'h205; post_cnt = 10;
        for (int p = 'h1F0; p < 'h220; p++) commit(30'(p));
        chk("t6_count", 64'(count), 64'd16);
        rd_req = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t6_pc", 64'(rd_pc), 64'('h200 + i));
        end
        rd_req = 0;
        flo = '0; fhi = '1; trig_en = 0;
        step();
`endif

        // randomized traffic, with a mid-run reset
        trig_pc = 30'h108;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            arm      = ($urandom_range(0, 59) == 0);
            valid    = ($urandom_range(0, 9) < 7);
            kill     = ($urandom_range(0, 4) == 0);
            pc       = 30'(30'h100 + $urandom_range(0, 15));
            insn     = $urandom;
            trig_en  = $urandom_range(0, 1) == 1;
            ext      = ($urandom_range(0, 39) == 0);
            post_cnt = DL'($urandom_range(0, 7));
            rd_req   = $urandom_range(0, 1) == 1;
            step();
        end
        clear_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
